// File: rtl/rom_oscillator_pkg.sv
// rom_oscillator_pkg: shared state encoding and default sizes for the oscillator burst controller.
package rom_oscillator_pkg;
    localparam int CNT_WIDTH     = 16;
    localparam int DRAIN_TIMEOUT = 64;
    typedef enum logic [2:0] {IDLE, DELAY, RUN, DRAIN, DONE} t_burst_state;
endpackage

// File: rtl/burst_down_counter.sv
// burst_down_counter: loadable down-counter flagging its final count of one.
module burst_down_counter #(
    parameter int INT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic [INT_CNT_WIDTH-1:0] i_load_val,
    input  logic                     i_dec,
    output logic                     o_last
);
    logic [INT_CNT_WIDTH-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst)         r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_dec)  r_cnt <= r_cnt - 1'b1;
    assign o_last = r_cnt == INT_CNT_WIDTH'(1);
endmodule

// File: rtl/rom_oscillator_burst_ctrl.sv
// rom_oscillator_burst_ctrl: drives the oscillator valid for one burst and tracks the returned samples.
module rom_oscillator_burst_ctrl
    import rom_oscillator_pkg::*;
#(
    parameter int INT_CNT_WIDTH     = CNT_WIDTH,
    parameter int INT_DRAIN_TIMEOUT = DRAIN_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [INT_CNT_WIDTH-1:0] i_burst_len,
    input  logic [INT_CNT_WIDTH-1:0] i_delay,
    input  logic                     i_abort,
    input  logic                     i_osc_valid,
    output logic                     o_ready,
    output logic                     o_busy,
    output logic                     o_osc_valid,
    output logic [INT_CNT_WIDTH-1:0] o_sample_cnt,
    output logic                     o_done,
    output logic                     o_aborted,
    output logic                     o_err
);
    t_burst_state             r_state, w_next;
    logic [INT_CNT_WIDTH-1:0] r_len, r_sample_cnt, r_drain, w_cnt_next;
    logic r_ready, r_busy, r_osc_valid, r_done, r_aborted, r_err;
    logic w_accept, w_abort, w_sample, w_full, w_reached, w_timeout, w_dly_last, w_len_last;

    assign w_accept  = r_state == IDLE && i_start && i_burst_len != '0;
    assign w_abort   = r_state inside {DELAY, RUN, DRAIN} && i_abort;
    assign w_sample  = r_state != IDLE && i_osc_valid && !w_abort;
    assign w_full    = r_sample_cnt == r_len;
    assign w_cnt_next = (w_sample && !w_full) ? r_sample_cnt + 1'b1 : r_sample_cnt;
    assign w_reached = w_cnt_next == r_len;
    assign w_timeout = r_state == DRAIN && r_drain == INT_CNT_WIDTH'(INT_DRAIN_TIMEOUT - 1) && !w_reached && !w_abort;

    burst_down_counter #(.INT_CNT_WIDTH(INT_CNT_WIDTH)) u_delay_cnt (
        .clk(clk), .rst(rst), .i_load(w_accept), .i_load_val(i_delay),
        .i_dec(r_state == DELAY), .o_last(w_dly_last)
    );
    burst_down_counter #(.INT_CNT_WIDTH(INT_CNT_WIDTH)) u_len_cnt (
        .clk(clk), .rst(rst), .i_load(w_accept), .i_load_val(i_burst_len),
        .i_dec(r_state == RUN), .o_last(w_len_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (i_delay != '0 ? DELAY : RUN) : IDLE;
            DELAY:   w_next = w_dly_last ? RUN : DELAY;
            RUN:     w_next = w_len_last ? (w_reached ? DONE : DRAIN) : RUN;
            DRAIN:   w_next = w_reached ? DONE : (w_timeout ? IDLE : DRAIN);
            default: w_next = IDLE;
        endcase
        if (w_abort)
            w_next = IDLE;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_osc_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_err        <= 1'b0;
            r_len        <= '0;
            r_sample_cnt <= '0;
            r_drain      <= '0;
        end else begin
            r_state      <= w_next;
            r_ready      <= w_next == IDLE;
            r_busy       <= w_next inside {DELAY, RUN, DRAIN};
            r_osc_valid  <= w_next == RUN;
            r_done       <= w_next == DONE;
            r_aborted    <= w_abort;
            r_err        <= (r_state == IDLE && i_start && i_burst_len == '0) || w_timeout || (w_sample && w_full);
            r_len        <= w_accept ? i_burst_len : r_len;
            r_sample_cnt <= w_accept ? '0 : w_cnt_next;
            r_drain      <= r_state == DRAIN ? r_drain + 1'b1 : '0;
        end

    assign o_ready      = r_ready;
    assign o_busy       = r_busy;
    assign o_osc_valid  = r_osc_valid;
    assign o_sample_cnt = r_sample_cnt;
    assign o_done       = r_done;
    assign o_aborted    = r_aborted;
    assign o_err        = r_err;
endmodule
